// File: rtl/dot_job_sequencer_pkg.sv
// Shared definitions for the dot-product job sequencer.
// Job FSM state encoding, operand memory layout and vector length.
// Imported by the top-level sequencer.
package dot_job_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_RUN    = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   localparam int         VEC_LEN   = 8;
   localparam logic [3:0] A_BASE    = 4'd0;
   localparam logic [3:0] B_BASE    = 4'd8;
   // Address of the final operand byte (B[VEC_LEN-1]); ends the load phase.
   localparam logic [3:0] LAST_ADDR = B_BASE + 4'(VEC_LEN - 1);

endpackage

// File: rtl/dot_job_watchdog.sv
// Counts cycles the engine spends in RUN and flags an engine that never finishes.
// Latency: expired is combinational from the counter; it asserts TIMEOUT-1 enabled cycles after clr.
// No backpressure: clr wins over en, counter saturates at its last value.
module dot_job_watchdog #(
   parameter int TIMEOUT = 128
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] timer;

   // Cycle counter: cleared at job start, advances while the engine runs, stops at its limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
      end else if (clr) begin
         timer <= '0;
      end else if (en && (timer != LAST)) begin
         timer <= timer + 1'b1;
      end
   end

   assign expired = (timer == LAST);

endmodule

// File: rtl/dot_job_sequencer.sv
// Job controller: takes a host command, optionally streams 16 operand bytes into memory, runs the engine, returns the result.
// Latency: operand write lands one cycle after acceptance; eng_start one cycle after the last byte (or the command).
// Backpressure: cmd_ready only in IDLE, in_ready only in LOAD; result is held until res_ready.
module dot_job_sequencer
   import dot_job_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 128,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic             cmd_reload,
   output logic             cmd_ready,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             res_valid,
   output logic [7:0]       res_data,
   input  logic             res_ready,
   output logic             eng_start,
   input  logic [3:0]       eng_mem_addr,
   input  logic             eng_done,
   input  logic [7:0]       eng_result,
   output logic [3:0]       mem_addr,
   output logic             mem_wr,
   output logic [7:0]       mem_wdata,
   output logic             busy,
   output logic             err_timeout,
   output logic [CNT_W-1:0] job_count
);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] wr_ptr;
   logic [3:0] mem_addr_q;
   logic       mem_wr_q;
   logic       wd_expired;

   dot_job_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == S_START),
      .en      (state == S_RUN),
      .expired (wd_expired)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a done from the engine beats a simultaneous watchdog expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               state_nxt = cmd_reload ? S_LOAD : S_START;
            end
         end
         S_LOAD: begin
            if (in_valid && (wr_ptr == LAST_ADDR)) begin
               state_nxt = S_START;
            end
         end
         S_START: state_nxt = S_RUN;
         S_RUN: begin
            if (eng_done) begin
               state_nxt = S_RESULT;
            end else if (wd_expired) begin
               state_nxt = S_IDLE;
            end
         end
         S_RESULT: begin
            if (res_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs; the engine owns the memory address port while running.
   // cmd_ready is masked during reset so every output reads 0 while rst is held.
   always_comb begin
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      eng_start = 1'b0;
      busy      = 1'b0;
      mem_addr  = mem_addr_q;
      mem_wr    = mem_wr_q;
      case (state)
         S_IDLE:  cmd_ready = ~rst;
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_START: begin
            eng_start = 1'b1;
            busy      = 1'b1;
         end
         S_RUN: begin
            busy     = 1'b1;
            mem_addr = eng_mem_addr;
            mem_wr   = 1'b0;
         end
         S_RESULT: busy = 1'b1;
         default: ;
      endcase
   end

   // Operand write path: each accepted byte is registered and written the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         mem_addr_q <= '0;
         mem_wdata  <= '0;
         mem_wr_q   <= 1'b0;
      end else begin
         mem_wr_q <= 1'b0;
         if ((state == S_IDLE) && cmd_valid && cmd_reload) begin
            wr_ptr <= A_BASE;
         end
         if ((state == S_LOAD) && in_valid) begin
            mem_addr_q <= wr_ptr;
            mem_wdata  <= in_data;
            mem_wr_q   <= 1'b1;
            if (wr_ptr != LAST_ADDR) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
      end
   end

   // Result channel and completed-job counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         job_count <= '0;
      end else if ((state == S_RUN) && eng_done) begin
         res_valid <= 1'b1;
         res_data  <= eng_result;
      end else if ((state == S_RESULT) && res_ready) begin
         res_valid <= 1'b0;
         job_count <= job_count + 1'b1;
      end
   end

   // Sticky watchdog flag: raised on abort, cleared when the next command is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_timeout <= 1'b0;
      end else if ((state == S_IDLE) && cmd_valid) begin
         err_timeout <= 1'b0;
      end else if ((state == S_RUN) && !eng_done && wd_expired) begin
         err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dot_job_sequencer.sv
// Self-checking bench for dot_job_sequencer with a behavioural engine and operand RAM.
// Expected results come from a reference memory image and a plain dot-product sum.
// Finishes on its own with one summary line.
module tb_dot_job_sequencer;

   localparam int TIMEOUT = 128;
   localparam int CNT_W   = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid, cmd_reload, cmd_ready;
   logic             in_valid, in_ready;
   logic [7:0]       in_data;
   logic             res_valid, res_ready;
   logic [7:0]       res_data;
   logic             eng_start, eng_done;
   logic [3:0]       eng_mem_addr;
   logic [7:0]       eng_result;
   logic [3:0]       mem_addr;
   logic             mem_wr;
   logic [7:0]       mem_wdata;
   logic             busy, err_timeout;
   logic [CNT_W-1:0] job_count;

   dot_job_sequencer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_reload   (cmd_reload),
      .cmd_ready    (cmd_ready),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .res_ready    (res_ready),
      .eng_start    (eng_start),
      .eng_mem_addr (eng_mem_addr),
      .eng_done     (eng_done),
      .eng_result   (eng_result),
      .mem_addr     (mem_addr),
      .mem_wr       (mem_wr),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .err_timeout  (err_timeout),
      .job_count    (job_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Operand RAM driven by the DUT write port, plus event counters.
   logic [7:0] ram [16];
   int         cyc = 0;
   int         wr_count = 0;
   int         start_count = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_wr) begin
         ram[mem_addr] <= mem_wdata;
         wr_count      <= wr_count + 1;
      end
      if (eng_start) start_count <= start_count + 1;
   end

   // Reference model: the memory image the host intends, and jobs completed.
   logic [7:0] exp_mem [16];
   int         exp_jobs = 0;

   function automatic logic [7:0] dot_ref();
      int s;
      s = 0;
      for (int i = 0; i < 8; i++) s += int'(exp_mem[i]) * int'(exp_mem[8+i]);
      return 8'(s);
   endfunction

   // Behavioural engine: walks A[i]/B[i] one element per cycle, then reports done.
   int         eng_mode = 0;   // 0 = normal, 1 = never done in time (late done after abort)
   int         run_entry_cyc = 0;
   logic [15:0] acc;
   logic [7:0]  ea, eb;

   initial begin
      eng_done     = 1'b0;
      eng_result   = 8'h00;
      eng_mem_addr = 4'h0;
      forever begin
         @(posedge clk); #1;
         if (eng_start) begin
            @(posedge clk); #1;
            run_entry_cyc = cyc;
            acc = 16'h0;
            for (int i = 0; i < 8; i++) begin
               eng_mem_addr = 4'(i);
               #1 chk("run_addr_a", 32'(mem_addr), 32'(i));
               ea = ram[i];
               eng_mem_addr = 4'(8 + i);
               #1 chk("run_addr_b", 32'(mem_addr), 32'(8 + i));
               eb = ram[8+i];
               acc = acc + 16'(ea) * 16'(eb);
               @(posedge clk); #1;
            end
            if (eng_mode == 0) begin
               eng_result = acc[7:0];
               eng_done   = 1'b1;
               @(posedge clk); #1;
               eng_done   = 1'b0;
            end else begin
               for (int k = 0; k < TIMEOUT + 100; k++) begin
                  if (err_timeout) break;
                  @(posedge clk); #1;
               end
               repeat (3) @(posedge clk);
               #1;
               eng_result = 8'h5A;
               eng_done   = 1'b1;
               @(posedge clk); #1;
               eng_done   = 1'b0;
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"},   32'(cmd_ready),   0);
      chk({tag, "_in_ready"},    32'(in_ready),    0);
      chk({tag, "_res_valid"},   32'(res_valid),   0);
      chk({tag, "_res_data"},    32'(res_data),    0);
      chk({tag, "_eng_start"},   32'(eng_start),   0);
      chk({tag, "_mem_addr"},    32'(mem_addr),    0);
      chk({tag, "_mem_wr"},      32'(mem_wr),      0);
      chk({tag, "_mem_wdata"},   32'(mem_wdata),   0);
      chk({tag, "_busy"},        32'(busy),        0);
      chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
      chk({tag, "_job_count"},   32'(job_count),   0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!cmd_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cmd_ready_idle", 32'(cmd_ready), 1);
   endtask

   task automatic issue_cmd(input bit reload);
      wait_idle();
      cmd_valid  = 1'b1;
      cmd_reload = reload;
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
      cmd_reload = 1'b0;
   endtask

   // gap: 0 = continuous, 1 = one idle cycle before every byte, 2 = random idles.
   task automatic run_job(input bit reload, input int gap, input int hold);
      int         wr0, st0, n, bad;
      bit         stable;
      logic [7:0] held;
      wr0 = wr_count;
      st0 = start_count;
      issue_cmd(reload);
      chk("err_cleared", 32'(err_timeout), 0);
      if (reload) begin
         for (int i = 0; i < 16; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               @(posedge clk); #1;
            end
            chk("in_ready", 32'(in_ready), 1);
            in_valid = 1'b1;
            in_data  = exp_mem[i];
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         chk("in_ready_drop", 32'(in_ready), 0);
      end
      chk("eng_start", 32'(eng_start), 1);
      if (hold == 0) res_ready = 1'b1;
      n = 0;
      while (!res_valid && n < TIMEOUT + 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("res_valid", 32'(res_valid), 1);
      chk("res_data", 32'(res_data), 32'(dot_ref()));
      held   = res_data;
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
         // Stray traffic while the result waits must be ignored.
         cmd_valid = 1'b1;
         in_valid  = 1'b1;
         in_data   = 8'($urandom);
         @(posedge clk); #1;
         if (res_data !== held || !res_valid || cmd_ready || !busy) stable = 1'b0;
      end
      cmd_valid = 1'b0;
      in_valid  = 1'b0;
      chk("res_hold_stable", 32'(stable), 1);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      exp_jobs++;
      chk("res_valid_clr", 32'(res_valid), 0);
      chk("busy_idle", 32'(busy), 0);
      chk("cmd_ready_back", 32'(cmd_ready), 1);
      chk("job_count", 32'(job_count), 32'(exp_jobs % 256));
      chk("write_count", 32'(wr_count - wr0), reload ? 32'd16 : 32'd0);
      chk("start_pulses", 32'(start_count - st0), 1);
      bad = 0;
      for (int i = 0; i < 16; i++) if (ram[i] !== exp_mem[i]) bad++;
      chk("mem_contents", 32'(bad), 0);
   endtask

   task automatic run_timeout();
      int n;
      bit saw;
      eng_mode = 1;
      issue_cmd(1'b0);
      saw = 1'b0;
      n = 0;
      while (!err_timeout && n < TIMEOUT + 100) begin
         if (res_valid) saw = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      chk("err_timeout", 32'(err_timeout), 1);
      chk("timeout_cycles", 32'(cyc - run_entry_cyc), 32'(TIMEOUT));
      chk("cmd_ready_after_to", 32'(cmd_ready), 1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (res_valid || busy) saw = 1'b1;
      end
      chk("late_done_ignored", 32'(saw), 0);
      chk("err_sticky", 32'(err_timeout), 1);
      chk("job_count_to", 32'(job_count), 32'(exp_jobs % 256));
      eng_mode = 0;
   endtask

   task automatic run_reset_mid_load();
      logic [7:0] nb [16];
      int bad;
      for (int i = 0; i < 16; i++) nb[i] = 8'($urandom);
      issue_cmd(1'b1);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = nb[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = nb[6];
      rst      = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      in_valid = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("rst_held");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      exp_jobs = 0;
      bad = 0;
      for (int i = 0; i < 5; i++) if (ram[i] !== nb[i]) bad++;
      chk("partial_load", 32'(bad), 0);
      chk("cmd_ready_post_rst", 32'(cmd_ready), 1);
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_reload = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      res_ready  = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // A = B = 1..8 -> 204 = 0xCC.
      for (int i = 0; i < 8; i++) begin
         exp_mem[i]   = 8'(i + 1);
         exp_mem[8+i] = 8'(i + 1);
      end
      run_job(1'b1, 0, 0);
      chk("job1_cc", 32'(dot_ref()), 32'h0000_00CC);

      // Rerun on existing memory, result held off for 20 cycles.
      run_job(1'b0, 0, 20);

      // A = B = 0x10 -> 2048 mod 256 = 0, with alternating valid gaps.
      for (int i = 0; i < 16; i++) exp_mem[i] = 8'h10;
      run_job(1'b1, 1, 2);

      run_timeout();
      run_job(1'b0, 0, 1);

      run_reset_mid_load();

      for (int j = 0; j < 6; j++) begin
         bit reload;
         reload = (j == 0) || ($urandom_range(0, 2) != 0);
         if (reload) for (int i = 0; i < 16; i++) exp_mem[i] = 8'($urandom);
         run_job(reload, int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/dot_job_sequencer.md
Name: dot_job_sequencer

Overview:
Job-level controller for the dot-product engine and its 16x8 operand memory. It accepts a command from the host and can stream 16 operand bytes into memory: A[0..7] go to addresses 0-7 and B[0..7] go to addresses 8-15. It then pulses the engine start, hands the memory address port to the engine, and returns the 8-bit result over a valid/ready channel. A watchdog catches an engine that never signals done.

Parameters:
TIMEOUT, 128, max cycles in RUN before abort (engine nominal job is ~60 cycles); must be >= 64
CNT_W, 8, width of the completed-job counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  host command request
cmd_reload  in  1  1 = load 16 bytes before running; 0 = run on existing memory contents
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
in_valid  in  1  operand byte valid
in_data  in  8  operand byte
in_ready  out  1  sequencer accepts operand byte
res_valid  out  1  result available
res_data  out  8  result byte (engine result, low 8 bits of sum)
res_ready  in  1  host consumes result
eng_start  out  1  one-cycle start pulse to engine
eng_mem_addr  in  4  engine memory address
eng_done  in  1  engine done pulse
eng_result  in  8  engine result
mem_addr  out  4  operand memory address
mem_wr  out  1  operand memory write enable
mem_wdata  out  8  operand memory write data
busy  out  1  state != IDLE
err_timeout  out  1  sticky watchdog flag
job_count  out  CNT_W  completed jobs, wraps

Behaviour:
- Reset values: all outputs 0. State IDLE, write pointer 0, timer 0. Memory contents are not touched.
- States: IDLE, LOAD, START, RUN, RESULT.
- IDLE: cmd_ready=1, in_ready=0.
  - On cmd_valid: clear err_timeout.
  - If cmd_reload=1: wr_ptr<=0 and go to LOAD. Otherwise go to START.
- LOAD: in_ready=1, cmd_ready=0.
  - Each handshake registers mem_addr<=wr_ptr, mem_wdata<=in_data, mem_wr<=1. The write therefore occurs the cycle after acceptance.
  - wr_ptr increments on each handshake.
  - Gaps in in_valid are allowed: mem_wr=0 in gap cycles.
  - After the 16th accept (wr_ptr=15), go to START. in_ready drops that same edge.
  - wr_ptr never wraps inside a job.
- START: eng_start=1 for exactly one cycle, timer<=0, then go to RUN.
- RUN:
  - mem_addr = eng_mem_addr combinationally; mem_wr forced 0.
  - On eng_done: res_data<=eng_result, res_valid<=1, go to RESULT.
  - Otherwise timer increments. When timer reaches TIMEOUT-1: set err_timeout<=1, go to IDLE, no result produced.
- RESULT:
  - res_valid and res_data held stable until res_ready.
  - On the handshake: res_valid<=0, job_count<=job_count+1 (wraps), go to IDLE.
  - A result can be consumed the same cycle it appears only if res_ready is already high. Minimum IDLE-return latency is 1 cycle after res_valid.
- mem_addr outside RUN is the registered write address. It holds its last value in IDLE, START and RESULT.
- eng_done outside RUN is ignored, e.g. a late done after timeout or a spurious pulse in RESULT.
- cmd_valid outside IDLE is not accepted (cmd_ready=0).
- in_valid outside LOAD is ignored and nothing is written.
- Asynchronous reset mid-job returns everything to reset values immediately. A partial load leaves memory partially overwritten.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE..RESULT, 3 bits), operand base addresses (A_BASE=0, B_BASE=8) and VEC_LEN=8.
- One natural sub-module: dot_job_watchdog, the RUN-cycle timer with clear/enable inputs and an expired output.
- Memory-port mux and FSM stay in the top.

Test Plan:
- Reload job with A=1,2..8 and B=1,2..8, in_valid continuous -> 16 writes to addresses 0..15 with matching data; one eng_start pulse; res_data=0xCC; job_count=1.
- Reload job with A=B=0x10 for all 8 entries, in_valid toggling every other cycle -> writes occur only on accepted cycles; res_data=0x00 (2048 mod 256); no extra mem_wr.
- Command with cmd_reload=0 after the first job -> no mem_wr, eng_start 1 cycle after accept, res_data=0xCC again; job_count=2.
- res_ready held low 20 cycles after res_valid -> res_data stable, cmd_ready=0, busy=1; accepts on the first res_ready cycle and returns to IDLE.
- Engine model never asserts done -> err_timeout=1 exactly TIMEOUT cycles after RUN entry, no res_valid, cmd_ready=1. A later eng_done is ignored. The next command clears err_timeout.
- rst asserted at the 7th operand byte -> all outputs 0 that cycle, state IDLE. A subsequent reload job completes correctly.
